mem_access_ctrl: RTL

- Sequencer for the memory-side datapath: MAR, the bidirectional MDR, and the synchronous RAM.
- The control unit issues a single-cycle read or write request. The block then steps MAR load, MDR load, RAM strobe and MDR capture in a fixed order, and reports completion with a one-cycle done pulse.
- Sits between the control unit and the MAR/MDR/RAM trio. It generates control strobes only and carries no data path.

---
 rtl/mem_access_ctrl_if.sv | 37 +++
 rtl/mem_access_ctrl.sv | 96 +++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// Handshake and strobe bundle between the control unit and the memory access sequencer.
// The master drives requests; the slave (the sequencer) drives the MAR/MDR/RAM strobes.
interface mem_access_ctrl_if;
    logic req;
    logic req_write;
    logic MAR_in;
    logic MDR_in;
    logic MDR_read;
    logic mem_read;
    logic mem_write;
    logic busy;
    logic done;

    modport master (
        output req,
        output req_write,
        input  MAR_in,
        input  MDR_in,
        input  MDR_read,
        input  mem_read,
        input  mem_write,
        input  busy,
        input  done
    );

    modport slave (
        input  req,
        input  req_write,
        output MAR_in,
        output MDR_in,
        output MDR_read,
        output mem_read,
        output mem_write,
        output busy,
        output done
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: steps MAR load, MDR load, RAM strobe and MDR capture for one
// read or write request and signals completion with a one-cycle done pulse.
module mem_access_ctrl #(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_WIDTH   = 4
) (
    input logic              clock,
    input logic              clear,
    mem_access_ctrl_if.slave bus
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LOAD_MAR   = 3'd1;
    localparam logic [2:0] LOAD_MDR   = 3'd2;
    localparam logic [2:0] MEM_ACCESS = 3'd3;
    localparam logic [2:0] CAPTURE    = 3'd4;
    localparam logic [2:0] DONE       = 3'd5;
    localparam int         NUM_STATES = 6;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MEM_LATENCY - 1);

    logic [2:0]           state_reg, state_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                 wr_reg, wr_next;

    // One-hot view of the state; unused encodings leave every bit low so all outputs drop.
    logic [NUM_STATES-1:0] in_state;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STATES; gi++) begin : g_state_decode
            assign in_state[gi] = (state_reg == 3'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_next    = wr_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req) begin
                    wr_next    = bus.req_write;
                    state_next = LOAD_MAR;
                end
            end
            LOAD_MAR: begin
                cnt_next   = '0;
                state_next = wr_reg ? LOAD_MDR : MEM_ACCESS;
            end
            LOAD_MDR: begin
                state_next = MEM_ACCESS;
            end
            MEM_ACCESS: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next   = '0;
                    state_next = wr_reg ? DONE : CAPTURE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            CAPTURE: begin
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            wr_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            wr_reg    <= wr_next;
        end
    end

    // Moore decode: outputs depend only on registered state and the latched access type.
    assign bus.MAR_in    = in_state[LOAD_MAR];
    assign bus.MDR_in    = in_state[LOAD_MDR] | in_state[CAPTURE];
    assign bus.MDR_read  = in_state[CAPTURE];
    assign bus.mem_read  = (in_state[MEM_ACCESS] & ~wr_reg) | in_state[CAPTURE];
    assign bus.mem_write = in_state[MEM_ACCESS] & wr_reg;
    assign bus.busy      = |in_state[NUM_STATES-1:1];
    assign bus.done      = in_state[DONE];

endmodule
